// File: rtl/sprite_sched_pkg.sv
// Shared types for the sprite ROM scheduler.
// Request bundle layout and pixel/coordinate widths.
package sprite_sched_pkg;

    localparam int SPRITE_DIM = 64;
    localparam int N_SPRITES  = 7;

    typedef logic [2:0] sprite_idx_t;
    typedef logic [5:0] coord_t;
    typedef logic [2:0] rgb_t;

    typedef struct packed {
        sprite_idx_t sprite;
        coord_t      x;
        coord_t      y;
    } sprite_req_t;

    function automatic sprite_req_t make_req(
        input sprite_idx_t s,
        input coord_t      x,
        input coord_t      y
    );
        sprite_req_t r;
        r.sprite = s;
        r.x      = x;
        r.y      = y;
        return r;
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Per-requester response FIFO of RGB pixels.
// Pointers carry a wrap bit so full/empty come from a compare.
module rsp_fifo
    import sprite_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_en_i,
    input  rgb_t wr_data_i,
    input  logic rd_en_i,
    output rgb_t rd_data_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    rgb_t        mem_q [DEPTH];
    logic        full;
    logic        do_rd;

    // Flags and next pointers
    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_rd    = rd_en_i && !empty_o;
        wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en_i);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Credits upstream make a full-FIFO write impossible
    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n) !(wr_en_i && full)
    );

endmodule

// File: rtl/sprite_rom_scheduler.sv
// Round-robin sharing of the sprite pixel ROM between reel renderers.
// Holds each ROM address ROM_LAT cycles and routes pixels back by id.
module sprite_rom_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int ROM_LAT   = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [3*N_REQ-1:0] req_sprite,
    input  logic [6*N_REQ-1:0] req_x,
    input  logic [6*N_REQ-1:0] req_y,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [3*N_REQ-1:0] rsp_rgb,
    output logic [2:0]         rom_sprite_idx,
    output logic [5:0]         rom_x,
    output logic [5:0]         rom_y,
    input  logic [2:0]         rom_pixel_rgb
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam int SW  = $clog2(ROM_LAT + 1);

    sprite_req_t      req [N_REQ];
    sprite_req_t      rom_q, rom_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [CW-1:0]    credit_q [N_REQ];
    logic [CW-1:0]    credit_d [N_REQ];
    logic [ROM_LAT:0] pv_q, pv_d;
    logic [IDW-1:0]   pid_q [ROM_LAT+1];
    logic [IDW-1:0]   pid_d [ROM_LAT+1];

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] pop;
    logic [N_REQ-1:0] wr_en;
    logic [N_REQ-1:0] empty;
    logic             slot_open;
    logic             any_gnt;
    logic             win_found;
    logic [IDW-1:0]   win_idx;
    int               idx;

    // Unpack flat request buses and mark eligible requesters
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req[i] = make_req(req_sprite[3*i +: 3],
                              req_x[6*i +: 6],
                              req_y[6*i +: 6]);
            elig[i] = req_valid[i] && (credit_q[i] != '0);
        end
    end

    // Round-robin search starting at the pointer
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
    end

    // One-hot grant, only while the issue slot is open
    always_comb begin
        slot_open = (cnt_q >= SW'(ROM_LAT));
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = slot_open && win_found && (win_idx == IDW'(i));
        end
        any_gnt   = |gnt;
        req_ready = gnt;
    end

    // Next state: spacing, pointer, ROM address, credits, in-flight ids
    always_comb begin
        if (any_gnt)        cnt_d = SW'(1);
        else if (!slot_open) cnt_d = cnt_q + SW'(1);
        else                cnt_d = cnt_q;

        rr_d = rr_q;
        if (any_gnt) begin
            rr_d = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + IDW'(1);
        end

        rom_d = rom_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) rom_d = req[i];
        end

        for (int i = 0; i < N_REQ; i++) begin
            credit_d[i] = credit_q[i] - CW'(gnt[i]) + CW'(pop[i]);
        end

        pv_d     = {pv_q[ROM_LAT-1:0], any_gnt};
        pid_d[0] = win_idx;
        for (int k = 1; k <= ROM_LAT; k++) begin
            pid_d[k] = pid_q[k-1];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_q <= '0;
            cnt_q <= SW'(ROM_LAT);
            rr_q  <= '0;
            pv_q  <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                credit_q[i] <= CW'(RSP_DEPTH);
            end
            for (int k = 0; k <= ROM_LAT; k++) begin
                pid_q[k] <= '0;
            end
        end else begin
            rom_q <= rom_d;
            cnt_q <= cnt_d;
            rr_q  <= rr_d;
            pv_q  <= pv_d;
            for (int i = 0; i < N_REQ; i++) begin
                credit_q[i] <= credit_d[i];
            end
            for (int k = 0; k <= ROM_LAT; k++) begin
                pid_q[k] <= pid_d[k];
            end
        end
    end

    // Capture routing and response handshake
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            wr_en[i]     = pv_q[ROM_LAT] &&
                           (pid_q[ROM_LAT] == IDW'(i));
            rsp_valid[i] = !empty[i];
            pop[i]       = rsp_valid[i] && rsp_ready[i];
        end
    end

    assign rom_sprite_idx = rom_q.sprite;
    assign rom_x          = rom_q.x;
    assign rom_y          = rom_q.y;

    for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
        rgb_t rd_data;

        rsp_fifo #(
            .DEPTH(RSP_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en_i  (wr_en[i]),
            .wr_data_i(rom_pixel_rgb),
            .rd_en_i  (pop[i]),
            .rd_data_o(rd_data),
            .empty_o  (empty[i])
        );

        assign rsp_rgb[3*i +: 3] = rd_data;
    end

endmodule

// File: tb/tb_sprite_rom_scheduler.sv
// Directed bench for sprite_rom_scheduler.
// ROM model: two-stage registered pixel from the ROM address.
module tb_sprite_rom_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [8:0]  req_sprite;
    logic [17:0] req_x;
    logic [17:0] req_y;
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_ready;
    logic [8:0]  rsp_rgb;
    logic [2:0]  rom_sprite_idx;
    logic [5:0]  rom_x;
    logic [5:0]  rom_y;
    logic [2:0]  rom_pixel_rgb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sprite_rom_scheduler #(
        .N_REQ    (3),
        .ROM_LAT  (2),
        .RSP_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_sprite    (req_sprite),
        .req_x         (req_x),
        .req_y         (req_y),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rgb       (rsp_rgb),
        .rom_sprite_idx(rom_sprite_idx),
        .rom_x         (rom_x),
        .rom_y         (rom_y),
        .rom_pixel_rgb (rom_pixel_rgb)
    );

    function automatic logic [2:0] pix(
        input logic [2:0] s,
        input logic [5:0] x,
        input logic [5:0] y
    );
        return 3'(int'(s) + 3 * int'(x) + 5 * int'(y));
    endfunction

    logic [2:0] p1, p2;
    always @(posedge clk) begin
        p1 <= pix(rom_sprite_idx, rom_x, rom_y);
        p2 <= p1;
    end
    assign rom_pixel_rgb = p2;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] s,
                           input logic [5:0] x, input logic [5:0] y);
        req_sprite[3*i +: 3] = s;
        req_x[6*i +: 6]      = x;
        req_y[6*i +: 6]      = y;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    logic [2:0] eg, ev, el;
    int id, rr, g1, n1, n;
    bit found;

    initial begin
        req_sprite = '0;
        req_x      = '0;
        req_y      = '0;

        // Reset state and single request
        do_reset();
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rom_s", 32'(rom_sprite_idx), 32'd0);
        chk("rst_rom_x", 32'(rom_x), 32'd0);
        chk("rst_rom_y", 32'(rom_y), 32'd0);
        set_req(0, 3'd2, 6'd25, 6'd2);
        req_valid = 3'b001;
        #1;
        chk("t1_gnt", 32'(req_ready), 32'd1);
        cyc();
        req_valid = '0;
        #1;
        chk("t1_rom_s_c1", 32'(rom_sprite_idx), 32'd2);
        chk("t1_rom_x_c1", 32'(rom_x), 32'd25);
        chk("t1_rom_y_c1", 32'(rom_y), 32'd2);
        chk("t1_ready_c1", 32'(req_ready), 32'd0);
        cyc();
        #1;
        chk("t1_rom_s_c2", 32'(rom_sprite_idx), 32'd2);
        chk("t1_rom_x_c2", 32'(rom_x), 32'd25);
        chk("t1_rom_y_c2", 32'(rom_y), 32'd2);
        cyc();
        #1;
        chk("t1_rsp_c3", 32'(rsp_valid), 32'd0);
        cyc();
        #1;
        chk("t1_rsp_c4", 32'(rsp_valid), 32'd1);
        chk("t1_rgb", 32'(rsp_rgb[2:0]), 32'd7);
        rsp_ready = 3'b001;
        cyc();
        rsp_ready = '0;
        #1;
        chk("t1_popped", 32'(rsp_valid), 32'd0);

        // All requesters continuously valid
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_req(i, 3'(i + 1), 6'(10 * i + 3), 6'(i + 7));
        end
        rsp_ready = 3'b111;
        req_valid = 3'b111;
        for (int t = 0; t < 18; t++) begin
            #1;
            eg = (t % 2 == 0) ? (3'b001 << ((t / 2) % 3)) : 3'b000;
            chk("t2_gnt", 32'(req_ready), 32'(eg));
            ev = (t >= 4 && t % 2 == 0) ?
                 (3'b001 << (((t - 4) / 2) % 3)) : 3'b000;
            chk("t2_rsp_valid", 32'(rsp_valid), 32'(ev));
            if (ev != 3'b000) begin
                id = ((t - 4) / 2) % 3;
                chk("t2_rgb", 32'(rsp_rgb[3*id +: 3]),
                    32'(pix(3'(id + 1), 6'(10 * id + 3), 6'(id + 7))));
            end
            if (t % 2 == 1) begin
                id = (t / 2) % 3;
                chk("t2_rom_x", 32'(rom_x), 32'(10 * id + 3));
            end
            cyc();
        end
        req_valid = '0;
        repeat (6) cyc();

        // Credit stall on requester 1
        do_reset();
        rsp_ready = 3'b101;
        req_valid = 3'b111;
        rr = 0;
        g1 = 0;
        n1 = 0;
        for (int t = 0; t < 40; t++) begin
            #1;
            eg = '0;
            if (t % 2 == 0) begin
                el    = {1'b1, (g1 < 4), 1'b1};
                found = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    id = (rr + k) % 3;
                    if (!found && el[id]) begin
                        found = 1'b1;
                        eg    = 3'b001 << id;
                        rr    = (id + 1) % 3;
                        if (id == 1) g1++;
                    end
                end
            end
            chk("t3_gnt", 32'(req_ready), 32'(eg));
            n1 += int'(req_ready[1]);
            cyc();
        end
        #1;
        chk("t3_n1", 32'(n1), 32'd4);
        chk("t3_rsp1", 32'(rsp_valid[1]), 32'd1);
        chk("t3_rgb1", 32'(rsp_rgb[5:3]), 32'(pix(3'd2, 6'd13, 6'd8)));
        rsp_ready = 3'b111;
        n1 = int'(req_ready[1]);
        cyc();
        rsp_ready = 3'b101;
        for (int t = 0; t < 15; t++) begin
            #1;
            n1 += int'(req_ready[1]);
            cyc();
        end
        chk("t3_regrant", 32'(n1), 32'd1);
        req_valid = '0;
        rsp_ready = 3'b111;
        repeat (8) cyc();

        // Pop and capture together on a FIFO holding 3
        do_reset();
        set_req(0, 3'd3, 6'd0, 6'd4);
        for (int t = 0; t < 10; t++) begin
            req_x[5:0] = 6'(t / 2 + 1);
            req_valid  = (t % 2 == 0 && t <= 6) ? 3'b001 : 3'b000;
            rsp_ready  = (t == 9) ? 3'b001 : 3'b000;
            #1;
            if (t % 2 == 0 && t <= 6) begin
                chk("t4_gnt", 32'(req_ready), 32'd1);
            end
            if (t == 8) chk("t4_occ3", 32'(rsp_valid), 32'd1);
            if (t == 9) begin
                chk("t4_head1", 32'(rsp_rgb[2:0]),
                    32'(pix(3'd3, 6'd1, 6'd4)));
            end
            cyc();
        end
        rsp_ready = 3'b001;
        for (int k = 2; k <= 4; k++) begin
            #1;
            chk("t4_valid", 32'(rsp_valid), 32'd1);
            chk("t4_order", 32'(rsp_rgb[2:0]),
                32'(pix(3'd3, 6'(k), 6'd4)));
            cyc();
        end
        #1;
        chk("t4_drained", 32'(rsp_valid), 32'd0);
        rsp_ready = '0;

        // Reset one cycle after a grant
        do_reset();
        set_req(0, 3'd6, 6'd63, 6'd63);
        req_valid = 3'b001;
        #1;
        chk("t5_gnt", 32'(req_ready), 32'd1);
        cyc();
        req_valid = '0;
        rst_n     = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            #1;
            chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
            chk("t5_rom", 32'({rom_sprite_idx, rom_x, rom_y}), 32'd0);
            cyc();
        end
        req_valid = 3'b001;
        n = 0;
        for (int t = 0; t < 20; t++) begin
            #1;
            n += int'(req_ready[0]);
            cyc();
        end
        chk("t5_credits", 32'(n), 32'd4);
        req_valid = '0;

        // Idle hold after a grant
        do_reset();
        set_req(2, 3'd5, 6'd40, 6'd63);
        req_valid = 3'b100;
        #1;
        chk("t6_gnt", 32'(req_ready), 32'd4);
        cyc();
        req_valid = '0;
        for (int t = 0; t < 10; t++) begin
            #1;
            chk("t6_rom_s", 32'(rom_sprite_idx), 32'd5);
            chk("t6_rom_x", 32'(rom_x), 32'd40);
            chk("t6_rom_y", 32'(rom_y), 32'd63);
            chk("t6_ready", 32'(req_ready), 32'd0);
            cyc();
        end
        set_req(1, 3'd1, 6'd1, 6'd1);
        req_valid = 3'b010;
        #1;
        chk("t6_wake", 32'(req_ready), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
